// File: rtl/barrel_shifter_pipe_amisha.sv
// -----------------------------------------------------------------------------
// barrel_shifter_pipe_amisha
//
// Pipelined barrel shifter. A WIDTH-bit operand is rotated or shifted by a
// per-operand amount. Stage k applies the 2^k step when bit k of the amount is
// set, so the pipeline is AMT_W = $clog2(WIDTH) stages deep. The block accepts
// one operand per cycle and returns results in order.
//
// Modes (mode_amisha):
//   00 ROR  rotate right
//   01 ROL  rotate left
//   10 SRL  logical shift right (zero fill)
//   11 SRA  arithmetic shift right (sign fill)
//
// Ports:
//   clk_amisha        clock, rising edge
//   reset_amisha      asynchronous active-high reset
//   in_valid_amisha   operand valid
//   in_ready_amisha   block can accept an operand this cycle
//   a_amisha          operand, WIDTH bits
//   amt_amisha        shift amount, AMT_W bits
//   mode_amisha       operation select, 2 bits
//   out_valid_amisha  result valid
//   out_ready_amisha  consumer accepts the result
//   y_amisha          result, WIDTH bits
//   zero_amisha       result is all zeros (only with BSH_ZERO_FLAG_EN)
//
// Optional feature macro: BSH_ZERO_FLAG_EN adds the registered zero flag.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid is never withdrawn while waiting for ready, and the payload is
// held stable until the transfer. in_ready_amisha depends only on the output
// side (out_valid_amisha, out_ready_amisha), never on in_valid_amisha.
// -----------------------------------------------------------------------------
module barrel_shifter_pipe_amisha #(
    parameter int  WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk_amisha,
    input  logic             reset_amisha,
    input  logic             in_valid_amisha,
    output logic             in_ready_amisha,
    input  logic [WIDTH-1:0] a_amisha,
    input  logic [AMT_W-1:0] amt_amisha,
    input  logic [1:0]       mode_amisha,
    output logic             out_valid_amisha,
    input  logic             out_ready_amisha,
`ifdef BSH_ZERO_FLAG_EN
    output logic             zero_amisha,
`endif
    output logic [WIDTH-1:0] y_amisha
);

    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_SRL = 2'b10;
    localparam logic [1:0] MODE_SRA = 2'b11;

    // One pipeline step: apply a fixed shift of sh bits when en is set.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input logic             en,
        input int               sh
    );
        logic signed [WIDTH-1:0] sd;
        logic [WIDTH-1:0]        r;
        sd = d;
        r  = d;
        if (en) begin
            case (mode)
                MODE_ROR: r = (d >> sh) | (d << (WIDTH - sh));
                MODE_ROL: r = (d << sh) | (d >> (WIDTH - sh));
                MODE_SRL: r = d >> sh;
                MODE_SRA: r = sd >>> sh;
                default:  r = d;
            endcase
        end
        return r;
    endfunction

    // Stage registers. The full amount travels with the operand; stage k
    // only looks at bit k of it.
    logic [WIDTH-1:0] data_q  [AMT_W];
    logic [AMT_W-1:0] amt_q   [AMT_W];
    logic [1:0]       mode_q  [AMT_W];
    logic [AMT_W-1:0] valid_q;

    // Inputs seen by each stage and the values it will register.
    logic [WIDTH-1:0] in_data  [AMT_W];
    logic [AMT_W-1:0] in_amt   [AMT_W];
    logic [1:0]       in_mode  [AMT_W];
    logic [AMT_W-1:0] in_valid;
    logic [WIDTH-1:0] data_d   [AMT_W];

    logic adv;

    // Global stall: the whole pipe moves only when the output slot is free
    // or being consumed this cycle.
    assign adv              = !out_valid_amisha || out_ready_amisha;
    assign in_ready_amisha  = adv;
    assign out_valid_amisha = valid_q[AMT_W-1];
    assign y_amisha         = data_q[AMT_W-1];

    always_comb begin
        in_data[0]  = a_amisha;
        in_amt[0]   = amt_amisha;
        in_mode[0]  = mode_amisha;
        in_valid[0] = in_valid_amisha;
        for (int k = 1; k < AMT_W; k++) begin
            in_data[k]  = data_q[k-1];
            in_amt[k]   = amt_q[k-1];
            in_mode[k]  = mode_q[k-1];
            in_valid[k] = valid_q[k-1];
        end
        for (int k = 0; k < AMT_W; k++) begin
            data_d[k] = shift_stage(in_data[k], in_mode[k], in_amt[k][k], 1 << k);
        end
    end

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            valid_q <= '0;
            for (int k = 0; k < AMT_W; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else if (adv) begin
            // Bubbles advance too; only their valid bit matters.
            valid_q <= in_valid;
            for (int k = 0; k < AMT_W; k++) begin
                data_q[k] <= data_d[k];
                amt_q[k]  <= in_amt[k];
                mode_q[k] <= in_mode[k];
            end
        end
    end

`ifdef BSH_ZERO_FLAG_EN
    // Registered with the final stage so it holds with y_amisha during stalls.
    logic zero_q;

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            zero_q <= 1'b0;
        end else if (adv) begin
            zero_q <= (data_d[AMT_W-1] == '0);
        end
    end

    assign zero_amisha = zero_q;
`endif

endmodule
